// File: rtl/lv_reg_acc_arb.sv
// Purpose: CRC-8 over a parallel data word, evaluated MSB first, init 0, polynomial POLY.
// Latency: purely combinational, no clock.
// Backpressure: none; the output follows the input in the same cycle.
module crc16to8_parallel #(
  parameter int             DW   = 16,
  parameter int             CW   = 8,
  parameter logic [CW-1:0]  POLY = 'h07
) (
  input  logic [DW-1:0] data_in,
  output logic [CW-1:0] crc_out
);

  logic [CW-1:0] crc_v;
  logic          fb;

  // Bit-serial LFSR unrolled over the whole input word.
  always_comb begin
    crc_v = '0;
    fb    = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      fb    = crc_v[CW-1] ^ data_in[i];
      crc_v = {crc_v[CW-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_out = crc_v;
  end

endmodule

// Purpose: arbitrate SPI and watchdog-scan accesses onto one register-file port, keep CRC shadows of scanned registers.
// Latency: write ack after 3 edges from first sampled request, read ack after 4; one DONE cycle between grants.
// Backpressure: requests are levels held until ack; the loser of a conflict waits, grants alternate round-robin.
module lv_reg_acc_arb #(
  parameter int                          REG_AW       = 7,
  parameter int                          REG_DW       = 8,
  parameter int                          REG_CRC_W    = 8,
  parameter logic [5:0][REG_CRC_W-1:0]   SCAN_RST_CRC = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_spi_req,
  input  logic                 i_spi_wr,
  input  logic [REG_AW-1:0]    i_spi_addr,
  input  logic [REG_DW-1:0]    i_spi_wdata,
  output logic                 o_spi_ack,
  output logic [REG_DW-1:0]    o_spi_rdata,
  input  logic                 i_wdg_scan_rd_req,
  input  logic [REG_AW-1:0]    i_wdg_scan_addr,
  output logic                 o_wdg_scan_ack,
  output logic [REG_DW-1:0]    o_wdg_scan_data,
  output logic [REG_CRC_W-1:0] o_wdg_scan_crc,
  output logic                 o_rf_en,
  output logic                 o_rf_wr,
  output logic [REG_AW-1:0]    o_rf_addr,
  output logic [REG_DW-1:0]    o_rf_wdata,
  input  logic [REG_DW-1:0]    i_rf_rdata,
  output logic                 o_rac_busy
);

  localparam int NSCAN = 6;
  // Scanned register addresses, index 0 in the low bits.
  localparam logic [NSCAN*7-1:0] SCAN_ADDR = {7'h30, 7'h0B, 7'h09, 7'h03, 7'h02, 7'h01};

  typedef enum logic [2:0] {IDLE, ACC, WAIT, RSP, DONE} state_t;

  state_t                            state;
  state_t                            state_nxt;
  logic                              grant_scan;
  logic                              last_grant_scan;
  logic                              spi_win;
  logic                              any_req;
  logic                              scan_hit;
  logic [2:0]                        scan_idx;
  logic [NSCAN-1:0][REG_CRC_W-1:0]   shadow;
  logic [REG_CRC_W-1:0]              crc16to8_out;

  assign any_req    = i_spi_req || i_wdg_scan_rd_req;
  // SPI wins when alone, or on a conflict when scan had the previous grant.
  assign spi_win    = i_spi_req && (!i_wdg_scan_rd_req || last_grant_scan);
  assign o_rac_busy = (state != IDLE);

  crc16to8_parallel #(
    .DW (1 + REG_AW + REG_DW),
    .CW (REG_CRC_W)
  ) u_crc (
    .data_in ({1'b1, o_rf_addr, o_rf_wdata}),
    .crc_out (crc16to8_out)
  );

  // Map the current register-file address onto a shadow slot, if it is scanned.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NSCAN; i++) begin
      if (o_rf_addr == REG_AW'(SCAN_ADDR[i*7 +: 7])) begin
        scan_hit = 1'b1;
        scan_idx = 3'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: writes skip WAIT since there is no read data to collect.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACC;
      ACC:     state_nxt = o_rf_wr ? RSP : WAIT;
      WAIT:    state_nxt = RSP;
      RSP:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, register-file strobes, shadow update, read capture and ack pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_scan      <= 1'b0;
      last_grant_scan <= 1'b1;
      o_rf_en         <= 1'b0;
      o_rf_wr         <= 1'b0;
      o_rf_addr       <= '0;
      o_rf_wdata      <= '0;
      o_spi_ack       <= 1'b0;
      o_spi_rdata     <= '0;
      o_wdg_scan_ack  <= 1'b0;
      o_wdg_scan_data <= '0;
      o_wdg_scan_crc  <= '0;
      shadow          <= SCAN_RST_CRC;
    end else begin
      o_rf_en        <= 1'b0;
      o_rf_wr        <= 1'b0;
      o_spi_ack      <= 1'b0;
      o_wdg_scan_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_scan      <= !spi_win;
            last_grant_scan <= !spi_win;
            o_rf_en         <= 1'b1;
            o_rf_wr         <= spi_win && i_spi_wr;
            o_rf_addr       <= spi_win ? i_spi_addr  : i_wdg_scan_addr;
            o_rf_wdata      <= spi_win ? i_spi_wdata : '0;
          end
        end
        ACC: begin
          if (o_rf_wr && scan_hit) shadow[scan_idx] <= crc16to8_out;
        end
        WAIT: begin
          if (grant_scan) begin
            o_wdg_scan_data <= i_rf_rdata;
            o_wdg_scan_crc  <= scan_hit ? shadow[scan_idx] : '0;
          end else begin
            o_spi_rdata     <= i_rf_rdata;
          end
        end
        RSP: begin
          if (grant_scan) o_wdg_scan_ack <= 1'b1;
          else            o_spi_ack      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lv_reg_acc_arb.sv
// Bench for lv_reg_acc_arb: directed scenarios followed by random transactions,
// with a transaction-level reference model (memory image, shadow CRCs, round-robin owner).
module tb_lv_reg_acc_arb;

  localparam logic [5:0][7:0] RST_CRC = {8'h3C, 8'h5A, 8'h96, 8'hC3, 8'hA5, 8'h0F};

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_spi_req = 1'b0;
  logic       i_spi_wr = 1'b0;
  logic [6:0] i_spi_addr = '0;
  logic [7:0] i_spi_wdata = '0;
  logic       o_spi_ack;
  logic [7:0] o_spi_rdata;
  logic       i_wdg_scan_rd_req = 1'b0;
  logic [6:0] i_wdg_scan_addr = '0;
  logic       o_wdg_scan_ack;
  logic [7:0] o_wdg_scan_data;
  logic [7:0] o_wdg_scan_crc;
  logic       o_rf_en;
  logic       o_rf_wr;
  logic [6:0] o_rf_addr;
  logic [7:0] o_rf_wdata;
  logic [7:0] i_rf_rdata = '0;
  logic       o_rac_busy;

  lv_reg_acc_arb #(
    .REG_AW(7), .REG_DW(8), .REG_CRC_W(8), .SCAN_RST_CRC(RST_CRC)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_spi_req(i_spi_req), .i_spi_wr(i_spi_wr), .i_spi_addr(i_spi_addr),
    .i_spi_wdata(i_spi_wdata), .o_spi_ack(o_spi_ack), .o_spi_rdata(o_spi_rdata),
    .i_wdg_scan_rd_req(i_wdg_scan_rd_req), .i_wdg_scan_addr(i_wdg_scan_addr),
    .o_wdg_scan_ack(o_wdg_scan_ack), .o_wdg_scan_data(o_wdg_scan_data),
    .o_wdg_scan_crc(o_wdg_scan_crc), .o_rf_en(o_rf_en), .o_rf_wr(o_rf_wr),
    .o_rf_addr(o_rf_addr), .o_rf_wdata(o_rf_wdata), .i_rf_rdata(i_rf_rdata),
    .o_rac_busy(o_rac_busy)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Edge counter and output activity counters, sampled 2 units after each rising edge.
  int cyc = 0;
  int en_cnt = 0, spi_ack_cnt = 0, scan_ack_cnt = 0, overlap_cnt = 0;
  always @(posedge i_clk) cyc++;
  always @(posedge i_clk) begin
    #2;
    if (o_rf_en) en_cnt++;
    if (o_spi_ack) spi_ack_cnt++;
    if (o_wdg_scan_ack) scan_ack_cnt++;
    if (o_spi_ack && o_wdg_scan_ack) overlap_cnt++;
  end

  // Register-file responder: read data appears one full cycle after the strobe, noise otherwise.
  logic [7:0] rf_mem [128];
  bit         rd_pend = 1'b0;
  logic [6:0] rd_addr = '0;
  always @(negedge i_clk) begin
    if (rd_pend) begin
      i_rf_rdata = rf_mem[rd_addr];
      rd_pend    = 1'b0;
    end else begin
      i_rf_rdata = 8'($urandom);
    end
    if (o_rf_en) begin
      if (o_rf_wr) rf_mem[o_rf_addr] = o_rf_wdata;
      else begin
        rd_pend = 1'b1;
        rd_addr = o_rf_addr;
      end
    end
  end

  // Reference model state.
  logic [6:0] scan_list [6] = '{7'h01, 7'h02, 7'h03, 7'h09, 7'h0B, 7'h30};
  logic [7:0] ref_mem [128];
  logic [7:0] shadow_m [6];
  bit         last_scan_m;
  logic [7:0] m_spi_rdata, m_scan_data, m_scan_crc;
  int         txn_en0, txn_spi0, txn_scan0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC as remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [6:0] a, input logic [7:0] d);
    logic [23:0] v;
    v = {1'b1, a, d, 8'h00};
    for (int i = 23; i >= 8; i--)
      if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
    return v[7:0];
  endfunction

  function automatic int scan_idx_of(input logic [6:0] a);
    for (int i = 0; i < 6; i++) if (scan_list[i] == a) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) shadow_m[i] = RST_CRC[i];
    last_scan_m = 1'b1;
    m_spi_rdata = '0;
    m_scan_data = '0;
    m_scan_crc  = '0;
  endtask

  // Apply one completed transaction to the model.
  task automatic model_apply(input bit is_scan, input bit wr, input logic [6:0] a, input logic [7:0] d);
    int idx;
    idx = scan_idx_of(a);
    if (!wr) begin
      if (is_scan) begin
        m_scan_data = ref_mem[a];
        m_scan_crc  = (idx >= 0) ? shadow_m[idx] : 8'h00;
      end else begin
        m_spi_rdata = ref_mem[a];
      end
    end else begin
      ref_mem[a] = d;
      if (idx >= 0) shadow_m[idx] = crc_ref(a, d);
    end
    last_scan_m = is_scan;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_spi_rdata"}, 32'(o_spi_rdata), 32'(m_spi_rdata));
    chk({tag, "_scan_data"}, 32'(o_wdg_scan_data), 32'(m_scan_data));
    chk({tag, "_scan_crc"}, 32'(o_wdg_scan_crc), 32'(m_scan_crc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {o_spi_ack, o_spi_rdata, o_wdg_scan_ack, o_wdg_scan_data, o_wdg_scan_crc,
              o_rf_en, o_rf_wr, o_rf_addr, o_rf_wdata, o_rac_busy}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic drive_req(input bit is_scan, input bit wr, input logic [6:0] a, input logic [7:0] d);
    txn_en0   = en_cnt;
    txn_spi0  = spi_ack_cnt;
    txn_scan0 = scan_ack_cnt;
    if (is_scan) begin
      i_wdg_scan_rd_req = 1'b1;
      i_wdg_scan_addr   = a;
    end else begin
      i_spi_req   = 1'b1;
      i_spi_wr    = wr;
      i_spi_addr  = a;
      i_spi_wdata = d;
    end
  endtask

  // Wait for the ack, check latency/data, drop the request (same or next cycle), check the idle return.
  task automatic finish_txn(input bit is_scan, input bit wr, input logic [6:0] a, input logic [7:0] d,
                            input int start_cyc, input bit drop_late, input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (is_scan ? o_wdg_scan_ack : o_spi_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - start_cyc), wr ? 32'd3 : 32'd4);
    chk({tag, "_other_ack"}, 32'(is_scan ? o_spi_ack : o_wdg_scan_ack), 32'd0);
    chk({tag, "_busy_done"}, 32'(o_rac_busy), 32'd1);
    model_apply(is_scan, wr, a, d);
    chk_outs(tag);
    if (drop_late) @(negedge i_clk);
    if (is_scan) i_wdg_scan_rd_req = 1'b0;
    else         i_spi_req = 1'b0;
    @(negedge i_clk);
    chk({tag, "_busy_idle"}, 32'(o_rac_busy), 32'd0);
    chk({tag, "_en_count"}, 32'(en_cnt - txn_en0), 32'd1);
    chk({tag, "_ack_count"}, 32'((spi_ack_cnt - txn_spi0) + (scan_ack_cnt - txn_scan0)), 32'd1);
    chk_outs({tag, "_hold"});
  endtask

  task automatic txn(input bit is_scan, input bit wr, input logic [6:0] a, input logic [7:0] d,
                     input bit drop_late, input string tag);
    int sc;
    drive_req(is_scan, wr, a, d);
    sc = cyc;
    finish_txn(is_scan, wr, a, d, sc, drop_late, tag);
  endtask

  initial begin
    int sc, prev, nack, seen_en;
    bit exp_scan, sa, ca;
    bit r_scan, r_wr, r_late;
    logic [6:0] r_addr;
    logic [7:0] r_data;

    for (int i = 0; i < 128; i++) begin
      rf_mem[i]  = 8'($urandom);
      ref_mem[i] = rf_mem[i];
    end
    rf_mem[7'h09]  = 8'h00;
    ref_mem[7'h09] = 8'h00;
    model_reset();

    // Reset state.
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset_outputs");
    i_rst_n = 1'b1;

    // Scan read of a scanned address with zero data, reset-value CRC.
    txn(1'b1, 1'b0, 7'h09, 8'h00, 1'b0, "scan09");
    chk("scan09_crc_rst", 32'(o_wdg_scan_crc), 32'(RST_CRC[3]));

    // SPI write then scan read of the same scanned register.
    txn(1'b0, 1'b1, 7'h03, 8'h5A, 1'b0, "spi_wr03");
    txn(1'b1, 1'b0, 7'h03, 8'h00, 1'b0, "scan03");
    chk("scan03_crc_new", 32'(o_wdg_scan_crc), 32'(crc_ref(7'h03, 8'h5A)));
    chk("scan03_data", 32'(o_wdg_scan_data), 32'h5A);

    // Write to an unscanned address leaves every shadow at its reset value.
    do_reset();
    txn(1'b0, 1'b1, 7'h10, 8'hFF, 1'b0, "spi_wr10");
    for (int i = 0; i < 6; i++) begin
      txn(1'b1, 1'b0, scan_list[i], 8'h00, 1'b0, $sformatf("shadow%0d", i));
      chk($sformatf("shadow%0d_rst", i), 32'(o_wdg_scan_crc), 32'(RST_CRC[i]));
    end

    // Both requesters held: grants alternate, starting with SPI after reset.
    do_reset();
    txn_en0 = en_cnt;
    i_spi_req = 1'b1; i_spi_wr = 1'b0; i_spi_addr = 7'h22;
    i_wdg_scan_rd_req = 1'b1; i_wdg_scan_addr = 7'h02;
    prev = -1;
    nack = 0;
    for (int n = 0; n < 60 && nack < 4; n++) begin
      @(negedge i_clk);
      sa = o_spi_ack;
      ca = o_wdg_scan_ack;
      if (sa || ca) begin
        exp_scan = !last_scan_m;
        chk($sformatf("alt%0d_who", nack), 32'(ca), 32'(exp_scan));
        chk($sformatf("alt%0d_overlap", nack), 32'(sa && ca), 32'd0);
        if (prev >= 0) chk($sformatf("alt%0d_spacing", nack), 32'(cyc - prev), 32'd5);
        prev = cyc;
        model_apply(exp_scan, 1'b0, exp_scan ? 7'h02 : 7'h22, 8'h00);
        chk_outs($sformatf("alt%0d", nack));
        nack++;
      end
    end
    chk("alt_ack_total", 32'(nack), 32'd4);
    i_spi_req = 1'b0;
    i_wdg_scan_rd_req = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("alt_busy_idle", 32'(o_rac_busy), 32'd0);
    chk("alt_en_count", 32'(en_cnt - txn_en0), 32'd4);
    chk("alt_no_overlap", 32'(overlap_cnt), 32'd0);

    // Reset pulse during WAIT of a scan read; the held request completes once afterwards.
    txn(1'b0, 1'b1, 7'h0B, 8'hC7, 1'b0, "spi_wr0B");
    drive_req(1'b1, 1'b0, 7'h0B, 8'h00);
    seen_en = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge i_clk);
      if (o_rf_en) begin
        seen_en = 1;
        break;
      end
    end
    chk("rstwait_en_seen", 32'(seen_en), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("rstwait_outputs");
    @(negedge i_clk);
    chk("rstwait_no_ack", 32'(scan_ack_cnt - txn_scan0), 32'd0);
    i_rst_n = 1'b1;
    txn_en0   = en_cnt;
    txn_spi0  = spi_ack_cnt;
    txn_scan0 = scan_ack_cnt;
    sc = cyc;
    finish_txn(1'b1, 1'b0, 7'h0B, 8'h00, sc, 1'b0, "rstwait_resume");
    chk("rstwait_crc_rst", 32'(o_wdg_scan_crc), 32'(RST_CRC[4]));

    // Scan request dropped one cycle after its ack.
    txn(1'b1, 1'b0, 7'h30, 8'h00, 1'b1, "late_drop");

    // Random traffic against the model.
    for (int t = 0; t < 40; t++) begin
      r_scan = 1'($urandom);
      r_wr   = r_scan ? 1'b0 : 1'($urandom);
      r_addr = ($urandom_range(0, 1) == 1) ? scan_list[$urandom_range(0, 5)] : 7'($urandom);
      r_data = 8'($urandom);
      r_late = 1'($urandom);
      txn(r_scan, r_wr, r_addr, r_data, r_late, $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
